mem_trace_emitter: RTL

- Producer end of the memory-trace interface. The load/store unit hands it one access record per completed access through a valid/ready port.
- Records are queued in a FIFO. They are replayed to the trace sink as a read-strobe (ren) or write-strobe (wen) pulse, with address, length and data registered alongside the pulse.
- The sink triggers on the rising edge of ren/wen. This block therefore guarantees a low cycle between consecutive pulses on each strobe, so back-to-back accesses are never merged into one trace call.

---
 rtl/trace_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/mem_trace_emitter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// Shared types and constants for the memory-trace emitter.
//   trace_rec_t      : one access record as queued between the LSU port and the emitter
//   emit_state_e     : emitter FSM states
//   TRACE_GAP_CYCLES : minimum low cycles between two strobes on the same output
//   trace_len()      : byte length presented to the sink for a given size code
package trace_pkg;

    localparam int unsigned TRACE_GAP_CYCLES = 2;
    localparam int unsigned GAP_CNT_W        = 2;

    typedef struct packed {
        logic        is_write;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
    } trace_rec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } emit_state_e;

    // Size code 3 is illegal; it is reported as a 4-byte access.
    function automatic logic [31:0] trace_len(input logic [1:0] size);
        return (size == 2'd3) ? 32'd4 : (32'd1 << size);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered full/empty flags.
//   clock, reset     : clock and synchronous active-high reset
//   push, wr_data    : write request and data (ignored when full)
//   pop, rd_data     : read request (ignored when empty); rd_data shows the head entry
//   full, empty      : registered occupancy flags
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr_nxt;
    logic [PW-1:0]    rd_ptr_nxt;
    logic             do_push;
    logic             do_pop;
    logic             full_nxt;
    logic             empty_nxt;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointers carry one extra MSB: equal index with differing MSB means full.
    always_comb begin
        wr_ptr_nxt = wr_ptr + PW'(do_push);
        rd_ptr_nxt = rd_ptr + PW'(do_pop);
        full_nxt   = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                     (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
        empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
    end

    // Pointer and flag registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            full   <= full_nxt;
            empty  <= empty_nxt;
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/mem_trace_emitter.sv
// Producer end of the memory-trace interface. Access records from the load/store
// unit are queued and replayed as single-cycle ren/wen strobes with registered
// address/length/data, spaced so the edge-triggered sink never merges two calls.
//   clock, reset                 : clock, synchronous active-high reset
//   ev_valid/ev_ready            : record handshake
//   ev_is_write/addr/size/data   : record payload
//   raddr/rlen/rdata/ren         : read-trace outputs
//   waddr/wlen/wdata/wen         : write-trace outputs
//   busy                         : queue non-empty or emitter active
//   drop_cnt                     : saturating count of records dropped while full
//   size_err                     : sticky flag for an accepted record with size code 3
module mem_trace_emitter
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned BLOCKING = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ev_valid,
    output logic             ev_ready,
    input  logic             ev_is_write,
    input  logic [31:0]      ev_addr,
    input  logic [1:0]       ev_size,
    input  logic [31:0]      ev_data,
    output logic [31:0]      raddr,
    output logic [31:0]      rlen,
    output logic [31:0]      rdata,
    output logic             ren,
    output logic [31:0]      waddr,
    output logic [31:0]      wlen,
    output logic [31:0]      wdata,
    output logic             wen,
    output logic             busy,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             size_err
);

    localparam int unsigned REC_W = $bits(trace_rec_t);

    trace_rec_t           ev_rec;
    trace_rec_t           head;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 drop;

    emit_state_e          state;
    emit_state_e          state_nxt;
    logic [GAP_CNT_W-1:0] gap_cnt;
    logic [GAP_CNT_W-1:0] gap_cnt_nxt;
    logic                 ren_nxt;
    logic                 wen_nxt;
    logic [31:0]          raddr_nxt;
    logic [31:0]          rlen_nxt;
    logic [31:0]          rdata_nxt;
    logic [31:0]          waddr_nxt;
    logic [31:0]          wlen_nxt;
    logic [31:0]          wdata_nxt;

    assign ev_rec = '{is_write: ev_is_write, addr: ev_addr, size: ev_size, data: ev_data};

    // Ready follows the registered full flag, so a same-cycle pop never frees a slot
    // for the incoming record.
    assign ev_ready  = (BLOCKING != 0) ? !fifo_full : 1'b1;
    assign fifo_push = ev_valid && ev_ready && !fifo_full;
    assign drop      = ev_valid && ev_ready && fifo_full;
    assign busy      = !fifo_empty || (state != IDLE);

    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (fifo_push),
        .wr_data (ev_rec),
        .pop     (fifo_pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Emitter next-state and output logic.
    always_comb begin
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        fifo_pop    = 1'b0;
        ren_nxt     = 1'b0;
        wen_nxt     = 1'b0;
        raddr_nxt   = raddr;
        rlen_nxt    = rlen;
        rdata_nxt   = rdata;
        waddr_nxt   = waddr;
        wlen_nxt    = wlen;
        wdata_nxt   = wdata;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = PULSE;
                    if (head.is_write) begin
                        wen_nxt   = 1'b1;
                        waddr_nxt = head.addr;
                        wlen_nxt  = trace_len(head.size);
                        wdata_nxt = head.data;
                    end else begin
                        ren_nxt   = 1'b1;
                        raddr_nxt = head.addr;
                        rlen_nxt  = trace_len(head.size);
                        rdata_nxt = head.data;
                    end
                end
            end
            PULSE: begin
                // The IDLE pop cycle supplies the last low cycle, so GAP
                // covers the remaining TRACE_GAP_CYCLES-1.
                gap_cnt_nxt = GAP_CNT_W'(TRACE_GAP_CYCLES - 2);
                state_nxt   = GAP;
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - GAP_CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Emitter state and registered trace outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            gap_cnt <= '0;
            ren     <= 1'b0;
            wen     <= 1'b0;
            raddr   <= '0;
            rlen    <= '0;
            rdata   <= '0;
            waddr   <= '0;
            wlen    <= '0;
            wdata   <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_cnt_nxt;
            ren     <= ren_nxt;
            wen     <= wen_nxt;
            raddr   <= raddr_nxt;
            rlen    <= rlen_nxt;
            rdata   <= rdata_nxt;
            waddr   <= waddr_nxt;
            wlen    <= wlen_nxt;
            wdata   <= wdata_nxt;
        end
    end

    // Drop counter (saturating) and sticky size error.
    always_ff @(posedge clock) begin
        if (reset) begin
            drop_cnt <= '0;
            size_err <= 1'b0;
        end else begin
            if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
            if (fifo_push && (ev_size == 2'd3)) begin
                size_err <= 1'b1;
            end
        end
    end

endmodule
